// File: rtl/countdown_timer.sv
// countdown_timer: loadable BCD MM:SS:cc countdown with expiry pulse and held expired flag.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the last loaded preset on expiry.
module countdown_timer #(
    parameter int CLOCK_COUNT = 999999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        load,
    input  logic [23:0] preset,
    output logic [23:0] digits,
    output logic        running,
    output logic        expired,
    output logic        expired_pulse
);
    localparam int PW = CLOCK_COUNT > 0 ? $clog2(CLOCK_COUNT + 1) : 1;
    localparam logic [PW-1:0] TERM = PW'(CLOCK_COUNT);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t        state, state_next;
    logic [PW-1:0] prescaler, pre_next;
    logic [23:0]   digits_next, clamped, dec;
    logic          pulse_next, tick, borrow;

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] m);
        return d > m ? m : d;
    endfunction

    assign clamped = {clamp(preset[23:20], 4'd5), clamp(preset[19:16], 4'd9),
                      clamp(preset[15:12], 4'd5), clamp(preset[11:8], 4'd9),
                      clamp(preset[7:4], 4'd9), clamp(preset[3:0], 4'd9)};
    assign tick    = state == RUN && prescaler == TERM;
    assign running = state == RUN;
    assign expired = state == EXPIRED;

    // Borrow cascade from hundredths upward; tens of seconds/minutes wrap to 5.
    always_comb begin
        dec = digits;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow)
                dec[4*i +: 4] = digits[4*i +: 4] == 4'd0 ? ((i == 3 || i == 5) ? 4'd5 : 4'd9)
                                                         : digits[4*i +: 4] - 4'd1;
            borrow = borrow && digits[4*i +: 4] == 4'd0;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [23:0] reload;
    always_ff @(posedge clk) begin
        if (reset)
            reload <= '0;
        else if (load && state != RUN)
            reload <= clamped;
    end
`endif

    always_comb begin
        state_next = state;
        digits_next = digits;
        pre_next = prescaler;
        pulse_next = 1'b0;
        if (load && state != RUN) begin
            state_next = IDLE;
            digits_next = clamped;
            pre_next = '0;
        end else if (state == RUN) begin
            pre_next = tick ? '0 : prescaler + 1'b1;
            digits_next = tick ? dec : digits;
            if (tick && digits == 24'h000001) begin
                pulse_next = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                digits_next = reload != '0 ? reload : dec;
                state_next = reload != '0 ? RUN : EXPIRED;
`else
                state_next = EXPIRED;
`endif
            end else if (start_stop) begin
                state_next = PAUSE;
            end
        end else if (start_stop) begin
            state_next = state == PAUSE ? RUN : state == EXPIRED ? IDLE : digits != '0 ? RUN : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            digits <= '0;
            prescaler <= '0;
            expired_pulse <= 1'b0;
        end else begin
            state <= state_next;
            digits <= digits_next;
            prescaler <= pre_next;
            expired_pulse <= pulse_next;
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench; expectations are queued with the edge they apply to.
module tb_countdown_timer;
    logic        clk = 1'b0;
    logic        reset, start_stop, load;
    logic [23:0] preset;
    logic [23:0] digits;
    logic        running, expired, expired_pulse;

    typedef struct {
        int          cyc;
        string       tag;
        logic [26:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;

    countdown_timer #(.CLOCK_COUNT(3)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .load(load), .preset(preset),
        .digits(digits), .running(running), .expired(expired), .expired_pulse(expired_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [26:0] got, logic [26:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got digits=%h run=%b exp=%b pulse=%b, want digits=%h run=%b exp=%b pulse=%b",
                     tag, got[26:3], got[2], got[1], got[0], want[26:3], want[2], want[1], want[0]);
        end
    endtask

    function automatic logic [26:0] obs(logic [23:0] d, logic r, logic e, logic p);
        return {d, r, e, p};
    endfunction

    always @(posedge clk) begin
        #1;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].cyc <= cyc) begin
                check(q[i].tag, {digits, running, expired, expired_pulse}, q[i].val);
                q.delete(i);
            end
    end

    // k = number of edges from now at which the expectation holds
    task automatic expect_at(int k, string tag, logic [26:0] v);
        q.push_back('{cyc + k, tag, v});
    endtask

    task automatic drive(logic ss, logic ld, logic [23:0] p);
        start_stop = ss;
        load = ld;
        preset = p;
    endtask

    task automatic wait_cycles(int n);
        repeat (n) begin
            @(negedge clk);
            start_stop = 1'b0;
            load = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 24'h0);
        expect_at(1, "reset1", obs(24'h0, 0, 0, 0));
        expect_at(2, "reset2", obs(24'h0, 0, 0, 0));
        wait_cycles(2);
        reset = 1'b0;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        drive(0, 1, 24'h000002);
        expect_at(1, "ar_load", obs(24'h000002, 0, 0, 0));
        wait_cycles(1);
        drive(1, 0, 24'h0);
        expect_at(1, "ar_run", obs(24'h000002, 1, 0, 0));
        expect_at(5, "ar_t1", obs(24'h000001, 1, 0, 0));
        expect_at(9, "ar_reload1", obs(24'h000002, 1, 0, 1));
        expect_at(10, "ar_after1", obs(24'h000002, 1, 0, 0));
        expect_at(13, "ar_t3", obs(24'h000001, 1, 0, 0));
        expect_at(17, "ar_reload2", obs(24'h000002, 1, 0, 1));
        wait_cycles(17);
        drive(1, 0, 24'h0);
        expect_at(1, "ar_pause", obs(24'h000002, 0, 0, 0));
        wait_cycles(1);
`else
        drive(0, 1, 24'h000003);
        expect_at(1, "load3", obs(24'h000003, 0, 0, 0));
        wait_cycles(1);
        drive(1, 0, 24'h0);
        expect_at(1, "run", obs(24'h000003, 1, 0, 0));
        expect_at(4, "pre_tick", obs(24'h000003, 1, 0, 0));
        expect_at(5, "tick1", obs(24'h000002, 1, 0, 0));
        expect_at(9, "tick2", obs(24'h000001, 1, 0, 0));
        expect_at(13, "expire", obs(24'h0, 0, 1, 1));
        expect_at(14, "expired_hold", obs(24'h0, 0, 1, 0));
        wait_cycles(14);
        drive(1, 0, 24'h0);
        expect_at(1, "ack", obs(24'h0, 0, 0, 0));
        wait_cycles(1);

        drive(0, 1, 24'h000001);
        expect_at(1, "load1", obs(24'h000001, 0, 0, 0));
        wait_cycles(1);
        drive(1, 0, 24'h0);
        expect_at(1, "run1", obs(24'h000001, 1, 0, 0));
        wait_cycles(4);
        drive(1, 0, 24'h0);
        expect_at(1, "ss_on_final", obs(24'h0, 0, 1, 1));
        expect_at(2, "ss_on_final_hold", obs(24'h0, 0, 1, 0));
        wait_cycles(2);
        drive(1, 0, 24'h0);
        expect_at(1, "ack2", obs(24'h0, 0, 0, 0));
        wait_cycles(1);
`endif

        drive(0, 1, 24'h010000);
        expect_at(1, "load_min", obs(24'h010000, 0, 0, 0));
        wait_cycles(1);
        drive(1, 0, 24'h0);
        expect_at(5, "cascade", obs(24'h005999, 1, 0, 0));
        wait_cycles(5);
        drive(1, 0, 24'h0);
        expect_at(1, "pause", obs(24'h005999, 0, 0, 0));
        expect_at(21, "frozen", obs(24'h005999, 0, 0, 0));
        wait_cycles(21);
        drive(1, 0, 24'h0);
        expect_at(3, "resume_held", obs(24'h005999, 1, 0, 0));
        expect_at(4, "resume_tick", obs(24'h005998, 1, 0, 0));
        wait_cycles(4);

        drive(0, 1, 24'h123456);
        expect_at(1, "load_in_run", obs(24'h005998, 1, 0, 0));
        wait_cycles(1);
        drive(1, 0, 24'h0);
        expect_at(1, "pause2", obs(24'h005998, 0, 0, 0));
        wait_cycles(1);
        drive(0, 1, 24'hFFFFFF);
        expect_at(1, "clamp_ff", obs(24'h595999, 0, 0, 0));
        wait_cycles(1);
        drive(0, 1, 24'h6A7B8C);
        expect_at(1, "clamp_mix", obs(24'h595989, 0, 0, 0));
        wait_cycles(1);
        drive(0, 1, 24'h0);
        expect_at(1, "load_zero", obs(24'h0, 0, 0, 0));
        wait_cycles(1);
        drive(1, 0, 24'h0);
        expect_at(1, "idle_zero", obs(24'h0, 0, 0, 0));
        expect_at(3, "idle_zero_hold", obs(24'h0, 0, 0, 0));
        wait_cycles(3);

        drive(0, 1, 24'h000500);
        expect_at(1, "load500", obs(24'h000500, 0, 0, 0));
        wait_cycles(1);
        drive(1, 0, 24'h0);
        expect_at(1, "run500", obs(24'h000500, 1, 0, 0));
        expect_at(5, "sec_borrow", obs(24'h000499, 1, 0, 0));
        wait_cycles(6);
        drive(1, 0, 24'h0);
        expect_at(1, "pause3", obs(24'h000499, 0, 0, 0));
        wait_cycles(1);
        drive(1, 1, 24'h000042);
        expect_at(1, "load_wins", obs(24'h000042, 0, 0, 0));
        expect_at(3, "load_wins_hold", obs(24'h000042, 0, 0, 0));
        wait_cycles(3);
        drive(1, 0, 24'h0);
        expect_at(1, "run42", obs(24'h000042, 1, 0, 0));
        wait_cycles(2);
        reset = 1'b1;
        expect_at(1, "reset_mid_run", obs(24'h0, 0, 0, 0));
        wait_cycles(1);
        reset = 1'b0;
        expect_at(3, "post_reset", obs(24'h0, 0, 0, 0));
        wait_cycles(5);

        if (q.size() != 0) begin
            $display("FAIL pending: %0d expectations never compared, want 0", q.size());
            n_mismatched += q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
